// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - instruction fetch front end with a 2-entry IF/ID buffer
//
// Purpose:
//   Issues one instruction ROM read per PC. Each returned word is queued with
//   its PC in a 2-entry FIFO. The FIFO drains into the registered IF/ID
//   outputs under control of the pipeline stall vector.
//   A flush drops every fetched entry, and also drops any read that is still
//   outstanding.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   i_stall[5:0]   stall vector: [0] PC held, [1] IF/ID stop, [2] ID stop
//   i_flush        discard fetched and in-flight instructions
//   i_if_pc        current PC from the PC register
//   i_if_ce        PC register chip enable (0 = no fetch)
//   o_rom_req      single-cycle ROM read request
//   o_rom_addr     ROM read address (the current PC)
//   i_rom_ack      ROM response valid, at least one cycle after the request
//   i_rom_rdata    ROM read data, valid with i_rom_ack
//   o_stallreq_if  ask the stall controller to hold the PC
//   o_id_pc        registered PC to ID
//   o_id_inst      registered instruction to ID (0 = bubble)
//   o_id_valid     ID outputs carry a real instruction

module if_id_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_if_pc,
  input  logic        i_if_ce,
  output logic        o_rom_req,
  output logic [31:0] o_rom_addr,
  input  logic        i_rom_ack,
  input  logic [31:0] i_rom_rdata,
  output logic        o_stallreq_if,
  output logic [31:0] o_id_pc,
  output logic [31:0] o_id_inst,
  output logic        o_id_valid
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BUSY    = 2'd1,
    S_HOLD    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_fifo_pc   [2];
  logic [31:0] r_fifo_inst [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_count;

  logic        w_push;
  logic        w_pop;
  logic        w_fifo_full;
  logic        w_fifo_empty;
  logic        w_stall_cond;

  // Stall bits 5:3 belong to later stages and are not used here.
  logic        w_unused_stall;
  assign w_unused_stall = ^i_stall[5:3];

  assign o_rom_addr   = i_if_pc;
  assign w_fifo_full  = (r_count == 2'd2);
  assign w_fifo_empty = (r_count == 2'd0);

  // A pop happens only from a non-empty FIFO, judged on the registered count.
  // A word pushed into an empty FIFO therefore reaches ID one edge later;
  // there is no same-cycle bypass.
  assign w_pop = !i_flush && !i_stall[1] && !w_fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_rom_req    = 1'b0;
    w_push       = 1'b0;
    w_stall_cond = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_stall_cond = 1'b1;
        // A request needs a free slot for its eventual ack. Holding this
        // rule here is what guarantees that every push finds room.
        if (i_if_ce && !i_flush && !w_fifo_full && !rst) begin
          o_rom_req   = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (i_rom_ack) begin
          if (i_flush) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_push = 1'b1;
            // When the PC is held by another stage, wait in HOLD. Returning
            // to IDLE here would fetch the same PC a second time.
            w_state_nxt = i_stall[0] ? S_HOLD : S_IDLE;
          end
        end else begin
          w_stall_cond = 1'b1;
          if (i_flush) begin
            w_state_nxt = S_DISCARD;
          end
        end
      end
      S_HOLD: begin
        if (i_flush || !i_stall[0]) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DISCARD: begin
        w_stall_cond = 1'b1;
        if (i_rom_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // No PC-hold request while the PC register is disabled or in reset.
  assign o_stallreq_if = w_stall_cond && i_if_ce;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      o_id_pc    <= 32'd0;
      o_id_inst  <= 32'd0;
      o_id_valid <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      o_id_pc    <= 32'd0;
      o_id_inst  <= 32'd0;
      o_id_valid <= 1'b0;
    end else begin
      if (w_push) begin
        assert (!w_fifo_full);
        r_fifo_pc[r_wr_ptr]   <= i_if_pc;
        r_fifo_inst[r_wr_ptr] <= i_rom_rdata;
        r_wr_ptr              <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase

      if (!i_stall[1]) begin
        if (!w_fifo_empty) begin
          o_id_pc    <= r_fifo_pc[r_rd_ptr];
          o_id_inst  <= r_fifo_inst[r_rd_ptr];
          o_id_valid <= 1'b1;
        end else begin
          o_id_pc    <= 32'd0;
          o_id_inst  <= 32'd0;
          o_id_valid <= 1'b0;
        end
      end else if (!i_stall[2]) begin
        // IF/ID is stopped but ID keeps moving. Feed ID a bubble so that the
        // held entry is not executed twice.
        o_id_pc    <= 32'd0;
        o_id_inst  <= 32'd0;
        o_id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_id_buf.sv
// tb/tb_if_id_buf.sv - self-checking bench for if_id_buf
module tb_if_id_buf;

  logic        clk;
  logic        i_rst;
  logic [5:0]  i_stall;
  logic        i_flush;
  logic [31:0] i_if_pc;
  logic        i_if_ce;
  logic        o_rom_req;
  logic [31:0] o_rom_addr;
  logic        i_rom_ack;
  logic [31:0] i_rom_rdata;
  logic        o_stallreq_if;
  logic [31:0] o_id_pc;
  logic [31:0] o_id_inst;
  logic        o_id_valid;

  if_id_buf dut (
    .clk          (clk),
    .rst          (i_rst),
    .i_stall      (i_stall),
    .i_flush      (i_flush),
    .i_if_pc      (i_if_pc),
    .i_if_ce      (i_if_ce),
    .o_rom_req    (o_rom_req),
    .o_rom_addr   (o_rom_addr),
    .i_rom_ack    (i_rom_ack),
    .i_rom_rdata  (i_rom_rdata),
    .o_stallreq_if(o_stallreq_if),
    .o_id_pc      (o_id_pc),
    .o_id_inst    (o_id_inst),
    .o_id_valid   (o_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic        ce;
    logic [31:0] pc;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic        sreq;
    logic        valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int          cyc;
  } exp_t;

  vec_t        vecs[$];
  exp_t        exp_q[$];
  int          n_err;
  int          n_checks;
  int          n_pops;
  int          cyc;
  int          rom_lat;
  int          rom_cnt;
  int          run_len;
  logic        rom_pend;
  logic [31:0] rom_a;
  logic        chk_lat;
  logic        load_pending;
  logic        m_req;
  logic        m_sreq;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        snap_valid;
  logic [31:0] snap_pc;
  logic [31:0] snap_inst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [5:0] st, input logic fl,
                              input logic ce, input logic [31:0] pc, input logic ack,
                              input logic [31:0] rd, input logic eq, input logic es,
                              input logic ev, input logic [31:0] ep, input logic [31:0] ei);
    vec_t v;
    v.rst = r; v.stall = st; v.flush = fl; v.ce = ce; v.pc = pc; v.ack = ack;
    v.rdata = rd; v.req = eq; v.sreq = es; v.valid = ev; v.id_pc = ep; v.id_inst = ei;
    return v;
  endfunction

  function automatic logic [31:0] rom_data(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    i_rst = v.rst; i_stall = v.stall; i_flush = v.flush; i_if_ce = v.ce;
    i_if_pc = v.pc; i_rom_ack = v.ack; i_rom_rdata = v.rdata;
    @(negedge clk);
    tag = $sformatf("v%0d", idx);
    chk({tag, "_rom_req"},  32'(o_rom_req),     32'(v.req));
    chk({tag, "_stallreq"}, 32'(o_stallreq_if), 32'(v.sreq));
    chk({tag, "_rom_addr"}, o_rom_addr,         v.pc);
    chk({tag, "_id_valid"}, 32'(o_id_valid),    32'(v.valid));
    chk({tag, "_id_pc"},    o_id_pc,            v.id_pc);
    chk({tag, "_id_inst"},  o_id_inst,          v.id_inst);
    @(posedge clk);
    #1;
  endtask

  // One cycle with a behavioural ROM and PC register around the DUT; ID output
  // words are checked against the scoreboard queue as they load.
  task automatic step();
    logic        s_req, s_sreq, s_ack, s_ce, s_st0, s_rst;
    logic [31:0] s_addr;
    exp_t        e;
    int          d;
    @(negedge clk);
    cyc++;
    s_req = o_rom_req; s_sreq = o_stallreq_if; s_ack = i_rom_ack; s_ce = i_if_ce;
    s_st0 = i_stall[0]; s_rst = i_rst; s_addr = o_rom_addr;
    m_req = o_rom_req; m_sreq = o_stallreq_if; m_valid = o_id_valid;
    m_pc = o_id_pc; m_inst = o_id_inst;
    if (load_pending && o_id_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'(o_id_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        n_pops++;
        chk("sb_pc", o_id_pc, e.pc);
        chk("sb_inst", o_id_inst, e.inst);
        if (chk_lat) begin
          d = cyc - e.cyc;
          chk("sb_ack_to_id", 32'(d >= 1 && d <= 2), 32'd1);
        end
      end
    end
    if (chk_lat && s_ack) begin
      chk("lat_sreq_on_ack", 32'(s_sreq), 32'd0);
      chk("lat_sreq_run", 32'(run_len), 32'(rom_lat));
    end
    run_len = s_sreq ? run_len + 1 : 0;
    load_pending = !i_rst && !i_stall[1] && !i_flush;
    @(posedge clk);
    #1;
    i_rom_ack = 1'b0;
    if (s_rst) rom_pend = 1'b0;
    if (s_req) begin
      rom_pend = 1'b1; rom_cnt = rom_lat; rom_a = s_addr;
    end
    if (rom_pend) begin
      rom_cnt--;
      if (rom_cnt == 0) begin
        rom_pend = 1'b0;
        i_rom_ack = 1'b1;
        i_rom_rdata = rom_data(rom_a);
        e.pc = rom_a; e.inst = rom_data(rom_a); e.cyc = cyc + 1;
        exp_q.push_back(e);
      end
    end
    if (!s_rst && s_ce && !s_sreq && !s_st0) i_if_pc = i_if_pc + 32'd4;
  endtask

  initial begin
    n_err = 0; n_checks = 0; n_pops = 0; cyc = 0; rom_lat = 1; rom_cnt = 0;
    run_len = 0; rom_pend = 1'b0; rom_a = 32'd0; chk_lat = 1'b0; load_pending = 1'b0;
    i_rst = 1'b1; i_stall = 6'd0; i_flush = 1'b0; i_if_pc = 32'd0; i_if_ce = 1'b0;
    i_rom_ack = 1'b0; i_rom_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;

    // reset, streaming with a 1-cycle ROM
    vecs.push_back(mk(1'b1, 6'h00, 1'b0, 1'b0, 32'h00, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b1, 6'h00, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00,   1'b0, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h00, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h00, 1'b1, 32'h11,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h04, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h04, 1'b1, 32'h22,   1'b0, 1'b0, 1'b1, 32'h0, 32'h11));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h08, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h08, 1'b1, 32'h33,   1'b0, 1'b0, 1'b1, 32'h4, 32'h22));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h0C, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h0C, 1'b0, 32'h00,   1'b0, 1'b0, 1'b1, 32'h8, 32'h33));
    // flush in BUSY, dropped late ack, next request right after DISCARD
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h40, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b1, 1'b1, 32'h40, 1'b0, 32'h00,   1'b0, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h40, 1'b0, 32'h00,   1'b0, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h40, 1'b1, 32'hDEAD, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h40, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h40, 1'b1, 32'h44,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h40, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h40, 1'b0, 32'h00,   1'b0, 1'b0, 1'b1, 32'h40, 32'h44));
    // flush coinciding with ack
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h50, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b1, 1'b1, 32'h50, 1'b1, 32'hBAD,  1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h50, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h50, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    // ack while stall[0]=1: HOLD, no refetch, then single request for PC+4
    vecs.push_back(mk(1'b0, 6'h01, 1'b0, 1'b1, 32'h60, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h01, 1'b0, 1'b1, 32'h60, 1'b1, 32'h66,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h01, 1'b0, 1'b1, 32'h60, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h01, 1'b0, 1'b1, 32'h60, 1'b0, 32'h00,   1'b0, 1'b0, 1'b1, 32'h60, 32'h66));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h60, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h64, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h64, 1'b1, 32'h6A,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h64, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h64, 1'b0, 32'h00,   1'b0, 1'b0, 1'b1, 32'h64, 32'h6A));
    // reset mid-BUSY, late ack ignored
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h70, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b1, 6'h00, 1'b0, 1'b0, 32'h70, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h70, 1'b1, 32'h77,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h70, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h70, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    // flush in IDLE suppresses request; flush in HOLD drops entry and exits HOLD
    vecs.push_back(mk(1'b0, 6'h00, 1'b1, 1'b1, 32'h80, 1'b0, 32'h00,   1'b0, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h80, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h01, 1'b0, 1'b1, 32'h80, 1'b1, 32'h88,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h01, 1'b1, 1'b1, 32'h80, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b1, 32'h84, 1'b0, 32'h00,   1'b1, 1'b1, 1'b0, 32'h0, 32'h0));
    // if_ce drops in BUSY: ack still pushed
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h84, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h84, 1'b1, 32'h8C,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h84, 1'b0, 32'h00,   1'b0, 1'b0, 1'b0, 32'h0, 32'h0));
    vecs.push_back(mk(1'b0, 6'h00, 1'b0, 1'b0, 32'h84, 1'b0, 32'h00,   1'b0, 1'b0, 1'b1, 32'h84, 32'h8C));

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // 3-cycle ROM latency streaming from PC 0x10
    i_rst = 1'b1; i_if_ce = 1'b0; i_stall = 6'd0; i_flush = 1'b0; i_rom_ack = 1'b0;
    step();
    i_rst = 1'b0; i_if_ce = 1'b1; i_if_pc = 32'h10; rom_lat = 3; chk_lat = 1'b1; run_len = 0;
    repeat (24) step();
    chk_lat = 1'b0;
    i_if_ce = 1'b0;
    repeat (10) step();
    chk("lat3_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("lat3_enough_fetches", 32'(n_pops >= 5), 32'd1);

    // ID stall fills the FIFO, IF/ID-only stall gives bubbles, then drain
    rom_lat = 1; i_if_ce = 1'b1;
    repeat (5) step();
    i_stall = 6'b000110;
    step();
    snap_valid = m_valid; snap_pc = m_pc; snap_inst = m_inst;
    chk("stall_snap_valid", 32'(snap_valid), 32'd1);
    repeat (3) begin
      step();
      chk("stall_id_valid_hold", 32'(m_valid), 32'(snap_valid));
      chk("stall_id_pc_hold", m_pc, snap_pc);
      chk("stall_id_inst_hold", m_inst, snap_inst);
    end
    i_stall = 6'b000010;
    step();
    chk("full_id_pc_hold", m_pc, snap_pc);
    chk("full_id_inst_hold", m_inst, snap_inst);
    chk("full_no_rom_req", 32'(m_req), 32'd0);
    chk("full_stallreq", 32'(m_sreq), 32'd1);
    chk("full_queue_two", 32'(exp_q.size()), 32'd2);
    step();
    chk("ifid_bubble_valid", 32'(m_valid), 32'd0);
    chk("ifid_bubble_inst", m_inst, 32'd0);
    chk("ifid_no_rom_req", 32'(m_req), 32'd0);
    i_stall = 6'b000000;
    step();
    chk("ifid_bubble2_valid", 32'(m_valid), 32'd0);
    chk("ifid_bubble2_inst", m_inst, 32'd0);
    chk("ifid_fifo_kept", 32'(exp_q.size()), 32'd2);
    repeat (12) step();
    i_if_ce = 1'b0;
    repeat (6) step();
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/if_id_buf.md
IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 Parameters: none; FIFO depth is fixed at 2 entries, each entry {pc[31:0], inst[31:0]}.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 stall  input  6  pipeline stall vector, 1 = stop; this block uses bit 0 (PC held), bit 1 (IF/ID) and bit 2 (ID).
REQ-005 flush  input  1  discards all fetched and in-flight instructions.
REQ-006 if_pc  input  32  current PC from the PC register.
REQ-007 if_ce  input  1  PC register chip-enable; 0 = no fetch.
REQ-008 rom_req  output  1  instruction ROM read request.
REQ-009 rom_addr  output  32  ROM read address; equals if_pc.
REQ-010 rom_ack  input  1  ROM response valid; arrives at least 1 cycle after rom_req.
REQ-011 rom_rdata  input  32  ROM read data, valid with rom_ack.
REQ-012 stallreq_if  output  1  request to the stall controller to hold the PC.
REQ-013 id_pc  output  32  registered PC to the ID stage.
REQ-014 id_inst  output  32  registered instruction to the ID stage; 0 is a bubble/NOP.
REQ-015 id_valid  output  1  id_pc/id_inst hold a real instruction.

Function
REQ-016 The FSM SHALL have four states: IDLE, BUSY (request outstanding), HOLD (fetched, PC not yet advanced) and DISCARD (flushed request outstanding).
REQ-017 In IDLE with if_ce=1, flush=0 and FIFO count<2, the block SHALL assert rom_req for exactly one cycle and enter BUSY; otherwise rom_req SHALL be 0.
REQ-018 In BUSY on rom_ack with flush=0, the block SHALL push {if_pc, rom_rdata} into the FIFO, then enter IDLE if stall[0]=0 or HOLD if stall[0]=1.
REQ-019 HOLD SHALL issue no request and SHALL return to IDLE on the first cycle with stall[0]=0, so that each PC is fetched exactly once.
REQ-020 stallreq_if SHALL be asserted combinationally in these cases:
  - if_ce=1 in IDLE;
  - BUSY without rom_ack;
  - DISCARD.
REQ-021 stallreq_if SHALL be 0 in HOLD, on the BUSY ack cycle, and whenever if_ce=0.
REQ-022 Because a request needs count<2 and only acks push, a push SHALL always find room; a push into a full FIFO is an assertion-checked error.
REQ-023 FIFO pointers are 1 bit and wrap modulo 2; count is 0..2. Simultaneous push and pop SHALL leave count unchanged.
REQ-024 If stall[1]=0: when the FIFO is non-empty, the block SHALL load the head into id_pc/id_inst, set id_valid=1 and pop; when the FIFO is empty, the outputs SHALL become a bubble (0/0/0).
REQ-025 If stall[1]=1 and stall[2]=0, the ID outputs SHALL become a bubble and the FIFO SHALL not be popped.
REQ-026 If stall[1]=1 and stall[2]=1, the ID outputs and the FIFO SHALL hold.
REQ-027 A pop and a push in the same cycle with the FIFO empty SHALL NOT bypass; the new entry reaches ID no earlier than the following cycle.
REQ-028 On flush, the block SHALL empty the FIFO and set the ID outputs to a bubble at the next edge.
REQ-029 On flush in BUSY without rom_ack, the block SHALL enter DISCARD; the next rom_ack SHALL be dropped and the block SHALL enter IDLE.
REQ-030 On flush in BUSY coinciding with rom_ack, the data SHALL be dropped and the block SHALL enter IDLE.
REQ-031 Flush SHALL take priority over all stall bits.
REQ-032 Flush in HOLD SHALL go to IDLE; flush in IDLE SHALL suppress that cycle's request.
REQ-033 if_ce falling to 0 in BUSY SHALL NOT cancel the outstanding request; its ack is pushed normally.

Reset
REQ-034 On rst=1 at a clock edge, the block SHALL set the state to IDLE, empty the FIFO, and set id_pc=0, id_inst=0, id_valid=0; reset overrides flush and ack.
REQ-035 During rst=1, rom_req SHALL be 0.
REQ-036 During rst=1, stallreq_if SHALL follow REQ-020 with if_ce (0 while the PC register is in reset).
REQ-037 Reset mid-BUSY SHALL discard the outstanding request state; a late rom_ack arriving in IDLE SHALL be ignored.

Verification
REQ-038 Streaming, 1-cycle ROM, no stalls: PCs 0x0, 0x4, 0x8 with data 0x11,0x22,0x33 -> id_inst takes 0x11,0x22,0x33 in order with id_pc matching; stallreq_if=1 in each request cycle and 0 in each ack cycle.
REQ-039 3-cycle ROM latency: rom_req at PC 0x10 -> stallreq_if high for 3 cycles, 0 on the ack cycle; entry {0x10, data} appears at ID 1-2 cycles later.
REQ-040 ID stall: stall=6'b000110 held 4 cycles with fetches continuing -> FIFO fills to 2, no further rom_req, ID outputs constant; on release, both entries drain in order.
REQ-041 stall=6'b000010 (IF/ID stop, ID go) -> id_inst=0, id_valid=0 for each such cycle; FIFO contents preserved.
REQ-042 Flush in BUSY, then ack with 0xDEAD -> 0xDEAD never appears at ID; FIFO empty; next request issues in the cycle after DISCARD exits.
REQ-043 Ack while stall[0]=1 from another stage -> FSM in HOLD with no second rom_req for the same PC; a single request for PC+4 follows after stall[0] drops.
